mc_ctrl_fsm: RTL
================

MC_CTRL_FSM -- requirements
Module: mc_ctrl_fsm

Interface
REQ-001 SHALL have parameter UART_GUARD_CYCLES, default 10000, cycles waited between UART_INIT and UART_WAIT; minimum 1.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum consecutive mem_ready-low cycles in a memory wait before trapping; 0 disables the timeout.
REQ-003 clk  in  1  clock; reset rst, asynchronous, active-low; clock clk.
REQ-004 rst  in  1  asynchronous active-low reset.
REQ-005 opcode  in  7  instruction opcode, held stable by the IR after FETCH.
REQ-006 funct7  in  7  instruction funct7.
REQ-007 funct3  in  3  instruction funct3.
REQ-008 mem_ready  in  1  memory handshake; current access completes in a cycle where it is 1.
REQ-009 uart_tx_done  in  1  UART transmitter finished the stop bit.
REQ-010 halt_clr  in  1  leaves HALT or TRAP for FETCH.
REQ-011 alu_src_a  out  2  ALU A select: 0=PC, 1=rs1, 2=zero, 3=old PC.
REQ-012 alu_src_b  out  2  ALU B select: 0=rs2, 1=const 4, 2=imm, 3=imm[4:0].
REQ-013 imm_sel  out  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J.
REQ-014 pc_src, pc_write, ir_write, reg_write, mem_read, mem_write, iord, branch, xor_zero, mem_to_reg  out  1 each  datapath strobes and selects.
REQ-015 alu_ctrl  out  5  ALU operation: ADD=00000, XOR=00100, SLT=00010, SLTU=00011.
REQ-016 uart_tx_send  out  1  start/hold UART transmission.
REQ-017 trap  out  1  set while in TRAP.
REQ-018 state_o  out  5  current state, encoded 0..16 in the order of REQ-020.

Function
REQ-019 All outputs SHALL be a pure function of state, opcode, funct7, funct3 and mem_ready (Moore, plus the mem_ready gating of REQ-022).
REQ-020 States: FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WRBACK, MEM_WRITE, REG_EXE, REG_WRBACK, BRANCH, IMMI_EXE, IMMI_WRBACK, JUMP, UART_INIT, UART_GUARD, UART_WAIT, HALT, TRAP.
REQ-021 DECODE dispatch: 0110011->REG_EXE; 0010011/0110111/0010111->IMMI_EXE; 0000011/0100011->MEM_ADDR; 1100011->BRANCH; 1101111/1100111->JUMP; 0001011->UART_INIT; 0101011->HALT; any other opcode, or branch funct3 010/011, ->TRAP.
REQ-022 FETCH, MEM_READ and MEM_WRITE SHALL hold until mem_ready=1. mem_read/mem_write stay asserted throughout; pc_write and ir_write are asserted only in the FETCH completion cycle, so the PC advances exactly once.
REQ-023 A wait counter SHALL clear on entering each wait state. When mem_ready=0 and the count equals MEM_TIMEOUT-1 (MEM_TIMEOUT>0), next state SHALL be TRAP.
REQ-024 FETCH: alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_src=0, iord=0.
REQ-025 DECODE: alu_src_a=3 (1 for jalr), alu_src_b=2, alu_ctrl=ADD, imm_sel=J for jal, I for jalr, B otherwise; reg_write=1 for jal/jalr.
REQ-026 REG_EXE: alu_src_a=1, alu_src_b=0, alu_ctrl={funct7[5],funct7[0],funct3}.
REQ-027 IMMI_EXE: lui uses a=2, b=2, imm U; auipc uses a=3, b=2, imm U; I-type shifts (funct3 001/101) use b=3 and alu_ctrl={funct7[5],funct7[0],funct3}; other I-type ops use b=2, alu_ctrl={2'b00,funct3}.
REQ-028 BRANCH: branch=1, pc_src=1, a=1, b=0, xor_zero=funct3[0]^funct3[2]; alu_ctrl=XOR for funct3 00x, SLT for 10x, SLTU for 11x; next FETCH.
REQ-029 MEM_ADDR: a=1, b=2, ADD, imm_sel I for load, S for store. *_WRBACK: reg_write=1 for one cycle; mem_to_reg=1 only in MEM_WRBACK.
REQ-030 JUMP: pc_write=1, pc_src=1, for one cycle.
REQ-031 UART_INIT lasts 1 cycle. UART_GUARD lasts exactly UART_GUARD_CYCLES cycles. UART_WAIT asserts uart_tx_send and exits to FETCH in the cycle after uart_tx_done=1.
REQ-032 HALT and TRAP SHALL hold with all strobes low until halt_clr=1, then go to FETCH; TRAP has priority over a simultaneous mem_ready.
REQ-033 In every state, any output not specified above SHALL be 0.

Reset
REQ-034 rst=0 SHALL force FETCH immediately, even mid-wait or mid-UART. The wait and guard counters clear, and trap=0.
REQ-035 After reset, outputs SHALL equal the FETCH values, with pc_write=ir_write=0 until mem_ready=1.

Verification
REQ-036 add (0110011, f7=0, f3=0), mem_ready=1 -> state sequence FETCH, DECODE, REG_EXE, REG_WRBACK, FETCH; alu_ctrl=00000; reg_write high 1 cycle.
REQ-037 lw, with mem_ready low 3 cycles in MEM_READ -> MEM_READ held 4 cycles, mem_read=1 and iord=1 throughout, then MEM_WRBACK with mem_to_reg=1.
REQ-038 MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, trap=1, pc_write never pulsed; halt_clr=1 -> FETCH.
REQ-039 bne (f3=001) -> BRANCH with alu_ctrl=00100, xor_zero=1, branch=1; bltu (f3=110) -> alu_ctrl=00011, xor_zero=1.
REQ-040 UART opcode, UART_GUARD_CYCLES=3 -> UART_INIT 1 cycle, UART_GUARD 3 cycles, UART_WAIT until uart_tx_done; rst pulsed mid-UART_GUARD -> FETCH and uart_tx_send=0.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle RV32-style control unit.
// A Moore FSM sequences fetch/decode/execute, with memory handshake waits,
// a bounded memory-wait timeout that traps, a UART send sequence with a
// guard delay, and HALT/TRAP states released by halt_clr.
module mc_ctrl_fsm #(
  parameter int UART_GUARD_CYCLES = 10000,
  parameter int MEM_TIMEOUT       = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       mem_ready,
  input  logic       uart_tx_done,
  input  logic       halt_clr,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_sel,
  output logic       pc_src,
  output logic       pc_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       branch,
  output logic       xor_zero,
  output logic       mem_to_reg,
  output logic [4:0] alu_ctrl,
  output logic       uart_tx_send,
  output logic       trap,
  output logic [4:0] state_o
);

  // State encoding, numbered in the order software sees on state_o
  localparam logic [4:0] S_FETCH       = 5'd0;
  localparam logic [4:0] S_DECODE      = 5'd1;
  localparam logic [4:0] S_MEM_ADDR    = 5'd2;
  localparam logic [4:0] S_MEM_READ    = 5'd3;
  localparam logic [4:0] S_MEM_WRBACK  = 5'd4;
  localparam logic [4:0] S_MEM_WRITE   = 5'd5;
  localparam logic [4:0] S_REG_EXE     = 5'd6;
  localparam logic [4:0] S_REG_WRBACK  = 5'd7;
  localparam logic [4:0] S_BRANCH      = 5'd8;
  localparam logic [4:0] S_IMMI_EXE    = 5'd9;
  localparam logic [4:0] S_IMMI_WRBACK = 5'd10;
  localparam logic [4:0] S_JUMP        = 5'd11;
  localparam logic [4:0] S_UART_INIT   = 5'd12;
  localparam logic [4:0] S_UART_GUARD  = 5'd13;
  localparam logic [4:0] S_UART_WAIT   = 5'd14;
  localparam logic [4:0] S_HALT        = 5'd15;
  localparam logic [4:0] S_TRAP        = 5'd16;

  // Opcodes recognised by the decoder
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_UART  = 7'b0001011;
  localparam logic [6:0] OP_HALT  = 7'b0101011;

  // Source selects, immediate formats and ALU operations
  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_RS1   = 2'd1;
  localparam logic [1:0] A_ZERO  = 2'd2;
  localparam logic [1:0] A_OLDPC = 2'd3;
  localparam logic [1:0] B_RS2   = 2'd0;
  localparam logic [1:0] B_FOUR  = 2'd1;
  localparam logic [1:0] B_IMM   = 2'd2;
  localparam logic [1:0] B_SHAMT = 2'd3;
  localparam logic [2:0] IMM_I   = 3'd0;
  localparam logic [2:0] IMM_S   = 3'd1;
  localparam logic [2:0] IMM_B   = 3'd2;
  localparam logic [2:0] IMM_U   = 3'd3;
  localparam logic [2:0] IMM_J   = 3'd4;
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00010;
  localparam logic [4:0] ALU_SLTU = 5'b00011;

  // Counter widths sized so the last count value is representable
  localparam int WAIT_W  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int GUARD_W = (UART_GUARD_CYCLES > 1) ? $clog2(UART_GUARD_CYCLES) : 1;
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST =
    (MEM_TIMEOUT > 0) ? WAIT_W'(MEM_TIMEOUT - 1) : '0;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(UART_GUARD_CYCLES - 1);

  logic [4:0]         state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [GUARD_W-1:0] guard_cnt_q, guard_cnt_d;
  logic [4:0]         dispatch_state;
  logic               in_mem_wait;
  logic               timeout_hit;
  logic               is_jal;
  logic               is_jalr;
  logic               is_shift_imm;
  logic               unused_funct7_bits;

  // Only funct7[5] and funct7[0] select ALU variants
  assign unused_funct7_bits = ^{funct7[6], funct7[4:1]};

  assign is_jal       = (opcode == OP_JAL);
  assign is_jalr      = (opcode == OP_JALR);
  assign is_shift_imm = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign in_mem_wait  = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                        (state_q == S_MEM_WRITE);
  assign timeout_hit  = TIMEOUT_EN && !mem_ready && (wait_cnt_q == WAIT_LAST);
  assign state_o      = state_q;

  // Opcode dispatch out of DECODE; unknown opcodes and branch funct3 01x trap
  always_comb begin
    dispatch_state = S_TRAP;
    case (opcode)
      OP_REG:                   dispatch_state = S_REG_EXE;
      OP_IMM, OP_LUI, OP_AUIPC: dispatch_state = S_IMMI_EXE;
      OP_LOAD, OP_STORE:        dispatch_state = S_MEM_ADDR;
      OP_BR:                    dispatch_state = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
      OP_JAL, OP_JALR:          dispatch_state = S_JUMP;
      OP_UART:                  dispatch_state = S_UART_INIT;
      OP_HALT:                  dispatch_state = S_HALT;
      default:                  dispatch_state = S_TRAP;
    endcase
  end

  // Next-state logic; memory waits trap once the low-ready budget is used up
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_DECODE:      state_d = dispatch_state;
      S_MEM_ADDR:    state_d = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready)        state_d = S_MEM_WRBACK;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_MEM_WRBACK:  state_d = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_TRAP;
      end
      S_REG_EXE:     state_d = S_REG_WRBACK;
      S_REG_WRBACK:  state_d = S_FETCH;
      S_BRANCH:      state_d = S_FETCH;
      S_IMMI_EXE:    state_d = S_IMMI_WRBACK;
      S_IMMI_WRBACK: state_d = S_FETCH;
      S_JUMP:        state_d = S_FETCH;
      S_UART_INIT:   state_d = S_UART_GUARD;
      S_UART_GUARD: begin
        if (guard_cnt_q == GUARD_LAST) state_d = S_UART_WAIT;
      end
      S_UART_WAIT: begin
        if (uart_tx_done) state_d = S_FETCH;
      end
      S_HALT, S_TRAP: begin
        if (halt_clr) state_d = S_FETCH;
      end
      default:       state_d = S_FETCH;
    endcase
  end

  // Wait and guard counters restart from zero whenever their state is entered
  always_comb begin
    wait_cnt_d  = '0;
    guard_cnt_d = '0;
    if (in_mem_wait && (state_d == state_q))
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    if ((state_q == S_UART_GUARD) && (state_d == S_UART_GUARD))
      guard_cnt_d = guard_cnt_q + GUARD_W'(1);
  end

  // State and counter registers with asynchronous active-low reset to FETCH
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= '0;
      guard_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      guard_cnt_q <= guard_cnt_d;
    end
  end

  // Moore output decode; mem_ready only gates the FETCH completion strobes
  always_comb begin
    alu_src_a    = A_PC;
    alu_src_b    = B_RS2;
    imm_sel      = IMM_I;
    alu_ctrl     = ALU_ADD;
    pc_src       = 1'b0;
    pc_write     = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    branch       = 1'b0;
    xor_zero     = 1'b0;
    mem_to_reg   = 1'b0;
    uart_tx_send = 1'b0;
    trap         = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_a = A_PC;
        alu_src_b = B_FOUR;
        mem_read  = 1'b1;
        pc_write  = mem_ready;
        ir_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = is_jalr ? A_RS1 : A_OLDPC;
        alu_src_b = B_IMM;
        imm_sel   = is_jal ? IMM_J : (is_jalr ? IMM_I : IMM_B);
        reg_write = is_jal || is_jalr;
      end
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_sel   = (opcode == OP_LOAD) ? IMM_I : IMM_S;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WRBACK: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
      end
      S_REG_EXE: begin
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        alu_ctrl  = {funct7[5], funct7[0], funct3};
      end
      S_REG_WRBACK, S_IMMI_WRBACK: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        branch    = 1'b1;
        pc_src    = 1'b1;
        alu_src_a = A_RS1;
        alu_src_b = B_RS2;
        xor_zero  = funct3[0] ^ funct3[2];
        case (funct3[2:1])
          2'b10:   alu_ctrl = ALU_SLT;
          2'b11:   alu_ctrl = ALU_SLTU;
          default: alu_ctrl = ALU_XOR;
        endcase
      end
      S_IMMI_EXE: begin
        if (opcode == OP_LUI) begin
          alu_src_a = A_ZERO;
          alu_src_b = B_IMM;
          imm_sel   = IMM_U;
        end else if (opcode == OP_AUIPC) begin
          alu_src_a = A_OLDPC;
          alu_src_b = B_IMM;
          imm_sel   = IMM_U;
        end else begin
          alu_src_a = A_RS1;
          imm_sel   = IMM_I;
          if (is_shift_imm) begin
            alu_src_b = B_SHAMT;
            alu_ctrl  = {funct7[5], funct7[0], funct3};
          end else begin
            alu_src_b = B_IMM;
            alu_ctrl  = {2'b00, funct3};
          end
        end
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 1'b1;
      end
      S_UART_WAIT: begin
        uart_tx_send = 1'b1;
      end
      S_TRAP: begin
        trap = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule
